// File: rtl/fsm_seq_driver.sv
// Self-test initiator for the x/y -> z sequence responder: resets it, steers it to a target state, checks z.
// Optional build macro FSM_PATH_CHECK_EN also checks z_in against the expected intermediate state during each step.
module fsm_seq_driver #(
  parameter int RST_CYCLES = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [1:0]       tgt,
  output logic             ready,
  output logic             fsm_rst,
  output logic             x,
  output logic             y,
  input  logic [2:0]       z_in,
  output logic             done,
  output logic             pass,
  output logic [2:0]       err_z,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RSTS  = 2'd1,
    STEP  = 2'd2,
    CHECK = 2'd3
  } state_t;

  localparam int             RCW      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_r;
  logic [RCW-1:0]   rst_cnt_r;
  logic [1:0]       step_r;
  logic [1:0]       tgt_r;
  logic             fail_r;
  logic             z_mis_s;
  logic             path_mis_s;

  // {x,y} driven during step k (0-based) of the sequence for target t
  function automatic logic [1:0] step_xy(input logic [1:0] t, input logic [1:0] k);
    logic [1:0] xy;
    xy = 2'b00;
    case (k)
      2'd0: xy = (t == 2'd0) ? 2'b11 : 2'b01;
      2'd1: xy = 2'b00;
      2'd2: begin
        case (t)
          2'd1:    xy = 2'b10;
          2'd3:    xy = 2'b11;
          default: xy = 2'b00;
        endcase
      end
      default: xy = 2'b00;
    endcase
    return xy;
  endfunction

  function automatic logic [1:0] last_step(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : 2'd2;
  endfunction

  function automatic logic [2:0] final_code(input logic [1:0] t);
    logic [2:0] c;
    case (t)
      2'd0:    c = 3'b001;
      2'd1:    c = 3'b001;
      2'd2:    c = 3'b010;
      2'd3:    c = 3'b101;
      default: c = 3'b000;
    endcase
    return c;
  endfunction

  // Responder state before the edge that ends step k: S7, S10, then S5
  function automatic logic [2:0] path_code(input logic [1:0] k);
    return (k == 2'd2) ? 3'b001 : 3'b000;
  endfunction

  // Final-state and intermediate-state compares against the live z_in
  always_comb begin
    z_mis_s    = 1'b0;
    path_mis_s = 1'b0;
    if (z_in != final_code(tgt_r)) begin
      z_mis_s = 1'b1;
    end else begin
      z_mis_s = 1'b0;
    end
`ifdef FSM_PATH_CHECK_EN
    if (z_in != path_code(step_r)) begin
      path_mis_s = 1'b1;
    end else begin
      path_mis_s = 1'b0;
    end
`else
    path_mis_s = 1'b0;
`endif
  end

  // Sequencer FSM with registered outputs and result bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      rst_cnt_r <= '0;
      step_r    <= 2'd0;
      tgt_r     <= 2'd0;
      fail_r    <= 1'b0;
      ready     <= 1'b1;
      fsm_rst   <= 1'b0;
      x         <= 1'b0;
      y         <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_z     <= 3'b000;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req) begin
            state_r   <= RSTS;
            ready     <= 1'b0;
            fsm_rst   <= 1'b1;
            tgt_r     <= tgt;
            rst_cnt_r <= '0;
            step_r    <= 2'd0;
            fail_r    <= 1'b0;
            err_z     <= 3'b000;
          end else begin
            ready <= 1'b1;
          end
        end
        RSTS: begin
          if (rst_cnt_r == RST_LAST) begin
            state_r  <= STEP;
            fsm_rst  <= 1'b0;
            step_r   <= 2'd0;
            {x, y}   <= step_xy(tgt_r, 2'd0);
          end else begin
            rst_cnt_r <= rst_cnt_r + {{(RCW-1){1'b0}}, 1'b1};
          end
        end
        STEP: begin
          // Only the first mismatch of a request is captured in err_z
          if (path_mis_s) begin
            fail_r <= 1'b1;
            if (!fail_r) begin
              err_z <= z_in;
            end
          end
          if (step_r == last_step(tgt_r)) begin
            state_r <= CHECK;
            x       <= 1'b0;
            y       <= 1'b0;
          end else begin
            step_r  <= step_r + 2'd1;
            {x, y}  <= step_xy(tgt_r, step_r + 2'd1);
          end
        end
        CHECK: begin
          state_r <= IDLE;
          ready   <= 1'b1;
          done    <= 1'b1;
          if (fail_r || z_mis_s) begin
            pass <= 1'b0;
            if (!fail_r) begin
              err_z <= z_in;
            end
            if (fail_cnt != CNT_MAX) begin
              fail_cnt <= fail_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end else begin
            pass <= 1'b1;
            if (pass_cnt != CNT_MAX) begin
              pass_cnt <= pass_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
        end
        default: begin
          state_r <= IDLE;
          ready   <= 1'b1;
          fsm_rst <= 1'b0;
          x       <= 1'b0;
          y       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_seq_driver.sv
// Directed, table-driven bench for fsm_seq_driver with a behavioural responder and z_in override.
module tb_fsm_seq_driver;

  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req = 1'b0;
  logic [1:0]       tgt = 2'd0;
  logic             ready, fsm_rst, x, y, done, pass;
  logic [2:0]       z_in, err_z;
  logic [CNT_W-1:0] pass_cnt, fail_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_pc   = 0;
  int exp_fc   = 0;

  logic       force_en  = 1'b0;
  logic [2:0] force_val = 3'b000;

  typedef enum logic [2:0] {R7, R10, R5, R6, R1, R9} rstate_t;
  rstate_t    rs = R7;
  logic [2:0] resp_z;

  typedef struct {
    logic [1:0]       tgt;
    int               len;
    logic [2:0][1:0]  xys;
    int               fk1;
    logic [2:0]       fz1;
    int               fk2;
    logic [2:0]       fz2;
    logic             exp_pass;
    logic [2:0]       exp_err;
  } vec_t;

  vec_t vecs[10];

  fsm_seq_driver #(.RST_CYCLES(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req(req), .tgt(tgt), .ready(ready),
    .fsm_rst(fsm_rst), .x(x), .y(y), .z_in(z_in), .done(done),
    .pass(pass), .err_z(err_z), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  // Responder model, independent of the driver
  always @(posedge clk) begin
    if (fsm_rst) rs <= R7;
    else begin
      case (rs)
        R7:      rs <= (y && !x) ? R10 : ((y && x) ? R9 : R7);
        R10:     rs <= R5;
        R5:      rs <= (!y && x) ? R9 : ((!y && !x) ? R6 : R1);
        R6:      rs <= R1;
        default: rs <= rs;
      endcase
    end
  end

  always_comb begin
    case (rs)
      R5, R9:  resp_z = 3'b001;
      R6:      resp_z = 3'b010;
      R1:      resp_z = 3'b101;
      default: resp_z = 3'b000;
    endcase
  end

  assign z_in = force_en ? force_val : resp_z;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tally(input logic p);
    if (p) exp_pc = (exp_pc < CNT_MAX) ? exp_pc + 1 : CNT_MAX;
    else   exp_fc = (exp_fc < CNT_MAX) ? exp_fc + 1 : CNT_MAX;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int last;
    logic [1:0] exp_xy;
    last = v.len + 2;
    @(negedge clk);
    check($sformatf("%s.ready_pre", tag), ready, 1);
    req = 1'b1;
    tgt = v.tgt;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      exp_xy = (k >= 1 && k <= v.len) ? v.xys[k-1] : 2'b00;
      check($sformatf("%s.k%0d.fsm_rst", tag, k), fsm_rst, (k == 0) ? 1 : 0);
      check($sformatf("%s.k%0d.xy", tag, k), {x, y}, exp_xy);
      check($sformatf("%s.k%0d.done", tag, k), done, (k == last) ? 1 : 0);
      check($sformatf("%s.k%0d.ready", tag, k), ready, (k == last) ? 1 : 0);
      if (k == last) begin
        tally(v.exp_pass);
        check($sformatf("%s.pass", tag), pass, v.exp_pass);
        check($sformatf("%s.err_z", tag), err_z, v.exp_err);
        check($sformatf("%s.pass_cnt", tag), pass_cnt, exp_pc);
        check($sformatf("%s.fail_cnt", tag), fail_cnt, exp_fc);
      end
      if (k == 0) begin
        req = 1'b0;
        tgt = ~v.tgt;
      end
      force_en  = (k == v.fk1) || (k == v.fk2);
      force_val = (k == v.fk1) ? v.fz1 : v.fz2;
    end
    force_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_rst;
    int n_done;
    vec_t v0;
    vecs[0] = '{2'd0, 1, {2'b00, 2'b00, 2'b11}, -1, 3'd0, -1, 3'd0, 1'b1, 3'b000};
    vecs[1] = '{2'd1, 3, {2'b10, 2'b00, 2'b01}, -1, 3'd0, -1, 3'd0, 1'b1, 3'b000};
    vecs[2] = '{2'd2, 3, {2'b00, 2'b00, 2'b01}, -1, 3'd0, -1, 3'd0, 1'b1, 3'b000};
    vecs[3] = '{2'd3, 3, {2'b11, 2'b00, 2'b01}, -1, 3'd0, -1, 3'd0, 1'b1, 3'b000};
    vecs[4] = '{2'd3, 3, {2'b11, 2'b00, 2'b01},  4, 3'b001, -1, 3'd0, 1'b0, 3'b001};
`ifdef FSM_PATH_CHECK_EN
    vecs[5] = '{2'd1, 3, {2'b10, 2'b00, 2'b01},  3, 3'b010, -1, 3'd0, 1'b0, 3'b010};
    vecs[8] = '{2'd2, 3, {2'b00, 2'b00, 2'b01},  1, 3'b011,  4, 3'b111, 1'b0, 3'b011};
`else
    vecs[5] = '{2'd1, 3, {2'b10, 2'b00, 2'b01},  3, 3'b010, -1, 3'd0, 1'b1, 3'b000};
    vecs[8] = '{2'd2, 3, {2'b00, 2'b00, 2'b01},  1, 3'b011,  4, 3'b111, 1'b0, 3'b111};
`endif
    vecs[6] = '{2'd2, 3, {2'b00, 2'b00, 2'b01},  4, 3'b000, -1, 3'd0, 1'b0, 3'b000};
    vecs[7] = '{2'd0, 1, {2'b00, 2'b00, 2'b11},  2, 3'b101, -1, 3'd0, 1'b0, 3'b101};
    vecs[9] = '{2'd1, 3, {2'b10, 2'b00, 2'b01}, -1, 3'd0, -1, 3'd0, 1'b1, 3'b000};
    v0 = vecs[0];

    // Reset values
    repeat (3) @(negedge clk);
    check("rst.ready", ready, 1);
    check("rst.fsm_rst", fsm_rst, 0);
    check("rst.xy", {x, y}, 2'b00);
    check("rst.done", done, 0);
    check("rst.pass", pass, 0);
    check("rst.err_z", err_z, 3'b000);
    check("rst.pass_cnt", pass_cnt, 0);
    check("rst.fail_cnt", fail_cnt, 0);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // req held through a whole request: one accept while busy, re-accept in the done cycle
    @(negedge clk);
    req = 1'b1;
    tgt = 2'd0;
    n_rst = 0;
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      if (k <= 3 && fsm_rst) n_rst++;
      if (k == 3) begin
        tally(1'b1);
        check("b2b.done1", done, 1);
        check("b2b.ready1", ready, 1);
        check("b2b.rst_pulses", n_rst, 1);
      end
      if (k == 4) begin
        check("b2b.reaccept_fsm_rst", fsm_rst, 1);
        check("b2b.reaccept_ready", ready, 0);
        req = 1'b0;
      end
      if (k == 7) begin
        tally(1'b1);
        check("b2b.done2", done, 1);
        check("b2b.pass", pass, 1);
        check("b2b.pass_cnt", pass_cnt, exp_pc);
      end
    end

    // Drive the pass counter into saturation
    for (int i = 0; i < 3; i++) run_vec(v0, $sformatf("sat%0d", i));
    check("sat.pass_cnt_max", pass_cnt, CNT_MAX);

    // Asynchronous reset while tgt1 is in STEP
    @(negedge clk);
    req = 1'b1;
    tgt = 2'd1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("mid.pre_y", y, 1);
    rst = 1'b0;
    #1;
    exp_pc = 0;
    exp_fc = 0;
    check("mid.fsm_rst", fsm_rst, 0);
    check("mid.xy", {x, y}, 2'b00);
    check("mid.done", done, 0);
    check("mid.ready", ready, 1);
    check("mid.pass_cnt", pass_cnt, 0);
    check("mid.fail_cnt", fail_cnt, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    n_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("mid.no_done", n_done, 0);
    run_vec(v0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
